// File: rtl/temp_sensor_reader.sv
// Read-only SPI (mode 0, MSB first) front end: triggers a sensor read periodically
// or on demand and presents the last completed code on a parallel bus.
module temp_sensor_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 sdi,
  output logic                 sclk,
  output logic                 cs_n,
  output logic [DATA_BITS-1:0] temp,
  output logic                 temp_valid,
  output logic                 busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_MAX = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [PER_W-1:0]     per_cnt_q, per_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] temp_q, temp_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic                 temp_valid_q, temp_valid_d;
  logic                 term_cnt;
  logic                 div_last;
  logic                 trigger;

  always_comb begin
    term_cnt = enable && (per_cnt_q == PER_MAX);
    trigger  = start || term_cnt;
    div_last = (div_cnt_q == DIV_MAX);

    // The period counter free-runs regardless of busy so periodic reads stay on a fixed grid.
    if (!enable || term_cnt) per_cnt_d = '0;
    else                     per_cnt_d = per_cnt_q + 1'b1;

    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    temp_d    = temp_q;
    sclk_d    = sclk_q;

    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        sclk_d    = 1'b0;
        if (trigger) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (div_last) begin
          state_d   = S_SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b1;
          shift_d   = (shift_q << 1) | DATA_BITS'(sdi);
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == BIT_MAX) begin
            // Load temp on entry to DONE so it is already updated while temp_valid is high.
            state_d = S_DONE;
            temp_d  = shift_q;
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = (shift_q << 1) | DATA_BITS'(sdi);
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_HOLD;
        div_cnt_d = '0;
      end
      S_HOLD: begin
        if (div_last) begin
          state_d   = S_IDLE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        div_cnt_d = '0;
        sclk_d    = 1'b0;
      end
    endcase

    // Outputs are registered from the next state so they change cleanly with the FSM.
    cs_n_d       = !((state_d == S_SETUP) || (state_d == S_SHIFT));
    busy_d       = (state_d != S_IDLE);
    temp_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      per_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      temp_q       <= '0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      temp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      per_cnt_q    <= per_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      temp_q       <= temp_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      temp_valid_q <= temp_valid_d;
    end
  end

  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign temp       = temp_q;
  assign temp_valid = temp_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench for temp_sensor_reader with a behavioural mode-0 sensor model.
module tb_temp_sensor_reader;

  localparam int CLK_DIV = 4;
  localparam int SP      = 200;
  localparam int DB      = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic          sdi = 1'b0;
  logic          sclk;
  logic          cs_n;
  logic [DB-1:0] temp;
  logic          temp_valid;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] code = 8'h00;
  int         bidx = 7;

  logic [31:0] tv_h   [0:299];
  logic [31:0] busy_h [0:299];
  logic [31:0] cs_h   [0:299];
  logic [31:0] sclk_h [0:299];
  logic [31:0] temp_h [0:299];

  temp_sensor_reader #(
    .CLK_DIV(CLK_DIV),
    .SAMPLE_PERIOD(SP),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .start(start),
    .sdi(sdi),
    .sclk(sclk),
    .cs_n(cs_n),
    .temp(temp),
    .temp_valid(temp_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Sensor: drives the MSB when selected, advances a bit after each sclk fall.
  always @(negedge cs_n) begin
    bidx = 7;
    sdi  = code[7];
  end

  always @(negedge sclk) begin
    if (!cs_n && bidx > 0) begin
      bidx = bidx - 1;
      sdi  = code[bidx];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offset 1 is the cycle after the edge that samples the first start pulse.
  task automatic run_seq(input int n, input int s1, input int s2, input int s3);
    for (int i = 0; i < n; i++) begin
      start = (i == s1) || (i == s2) || (i == s3);
      tick();
      tv_h[i+1]   = 32'(temp_valid);
      busy_h[i+1] = 32'(busy);
      cs_h[i+1]   = 32'(cs_n);
      sclk_h[i+1] = 32'(sclk);
      temp_h[i+1] = 32'(temp);
    end
    start = 1'b0;
  endtask

  function automatic int count_tv(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (tv_h[i] == 1) n++;
    return n;
  endfunction

  task automatic wait_tv(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (temp_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int rises;
    int highs;
    int e1, e2, e3;
    int n_tv, pos_tv;

    // Reset state
    tick();
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_temp", 32'(temp), 0);
    chk("rst_temp_valid", 32'(temp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Single read of 0xA5
    code = 8'hA5;
    run_seq(80, 0, -1, -1);
    chk("rd_cs_low_k1", cs_h[1], 0);
    chk("rd_busy_k1", busy_h[1], 1);
    chk("rd_sclk_setup", sclk_h[4], 0);
    chk("rd_sclk_first_hi", sclk_h[5], 1);
    chk("rd_sclk_hi_end", sclk_h[8], 1);
    chk("rd_sclk_first_lo", sclk_h[9], 0);
    chk("rd_sclk_last_hi", sclk_h[64], 1);
    chk("rd_sclk_last_lo", sclk_h[68], 0);
    rises = 0;
    highs = 0;
    for (int i = 1; i <= 80; i++) begin
      if (sclk_h[i] == 1) highs++;
      if (i > 1 && sclk_h[i] == 1 && sclk_h[i-1] == 0) rises++;
    end
    chk("rd_sclk_pulses", 32'(rises), 8);
    chk("rd_sclk_high_cycles", 32'(highs), 32);
    chk("rd_temp_before", temp_h[68], 0);
    chk("rd_tv_at_69", tv_h[69], 1);
    chk("rd_temp_at_69", temp_h[69], 32'h0A5);
    chk("rd_tv_count", 32'(count_tv(1, 80)), 1);
    chk("rd_cs_low_68", cs_h[68], 0);
    chk("rd_cs_high_69", cs_h[69], 1);
    chk("rd_busy_73", busy_h[73], 1);
    chk("rd_busy_74", busy_h[74], 0);
    chk("rd_temp_stable", temp_h[80], 32'h0A5);

    // Code sweep 0..255
    for (int c = 0; c < 256; c++) begin
      code = 8'(c);
      run_seq(76, 0, -1, -1);
      chk("sweep_temp", temp_h[69], 32'(c));
      chk("sweep_tv_count", 32'(count_tv(1, 76)), 1);
    end

    // Triggers while busy are dropped
    code = 8'h81;
    run_seq(160, 0, 10, 71);
    chk("drop_tv_count", 32'(count_tv(1, 160)), 1);
    chk("drop_tv_at_69", tv_h[69], 1);
    chk("drop_temp", temp_h[69], 32'h081);
    chk("drop_busy_74", busy_h[74], 0);
    chk("drop_busy_80", busy_h[80], 0);
    code = 8'h42;
    run_seq(76, 0, -1, -1);
    chk("drop_next_temp", temp_h[69], 32'h042);
    chk("drop_next_tv", 32'(count_tv(1, 76)), 1);

    // Reset mid-shift during bit 4
    code = 8'hFF;
    run_seq(38, 0, -1, -1);
    chk("mid_sclk_before", sclk_h[38], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", 32'(sclk), 0);
    chk("mid_rst_cs_n", 32'(cs_n), 1);
    chk("mid_rst_temp", 32'(temp), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    n_tv = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (temp_valid === 1'b1 || cs_n !== 1'b1) n_tv++;
    end
    chk("mid_no_activity", 32'(n_tv), 0);
    code = 8'h5A;
    run_seq(76, 0, -1, -1);
    chk("mid_next_temp", temp_h[69], 32'h05A);
    chk("mid_next_tv", 32'(count_tv(1, 76)), 1);

    // Periodic mode
    code = 8'h3C;
    enable = 1'b1;
    wait_tv(SP + 100, e1);
    chk("per_first_seen", 32'(e1 >= 0), 1);
    chk("per_temp1", 32'(temp), 32'h03C);
    wait_tv(SP + 10, e2);
    chk("per_gap1", 32'(e2 - e1), SP);
    chk("per_temp2", 32'(temp), 32'h03C);
    wait_tv(SP + 10, e3);
    chk("per_gap2", 32'(e3 - e2), SP);

    // Start coincident with terminal count
    for (int i = 0; i < 131; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("simul_busy", 32'(busy), 1);
    n_tv = 0;
    pos_tv = -1;
    while (cyc < e3 + 340) begin
      tick();
      if (temp_valid === 1'b1) begin
        n_tv++;
        pos_tv = cyc;
      end
    end
    chk("simul_tv_count", 32'(n_tv), 1);
    chk("simul_tv_pos", 32'(pos_tv - e3), SP);

    // Drop enable during the next periodic transfer
    enable = 1'b0;
    n_tv = 0;
    pos_tv = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (temp_valid === 1'b1) begin
        n_tv++;
        pos_tv = cyc;
      end
    end
    chk("dis_tv_count", 32'(n_tv), 1);
    chk("dis_tv_pos", 32'(pos_tv - e3), 2 * SP);
    chk("dis_temp", 32'(temp), 32'h03C);
    chk("dis_busy_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
